// File: rtl/flag_bank_pkg.sv
// Shared op codes and FSM state constants for the flag bank arbiter.
package flag_bank_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARB   = 2'b01,
        ST_APPLY = 2'b10
    } state_t;

endpackage

// File: rtl/flag_bank_arbiter_if.sv
// Requester-side bus of the flag bank arbiter: request vector, per-requester op/mask/data, completion.
interface flag_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8
);
    // Handshake: req[i] acts as valid and must hold req/op/mask/data stable until
    // ack[i] pulses for one cycle; a req still high on the following edge is a new request.
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      op;
    logic [NFLAGS*NREQ-1:0] mask;
    logic [NFLAGS*NREQ-1:0] data;
    logic [NREQ-1:0]        ack;
    logic [NFLAGS-1:0]      flags;
    logic                   busy;

    modport master (output req, op, mask, data, input ack, flags, busy);
    modport slave  (input req, op, mask, data, output ack, flags, busy);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest index at or above ptr with req set, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);
    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/flag_bank_arbiter.sv
// Round-robin arbiter serialising set/clear/toggle/write operations onto one shared flag register.
module flag_bank_arbiter
    import flag_bank_pkg::*;
#(
    parameter int                NREQ        = 4,
    parameter int                NFLAGS      = 8,
    parameter logic [NFLAGS-1:0] RESET_FLAGS = '0
) (
    input  logic                 s_clock,
    input  logic                 preset,
    flag_bank_arbiter_if.slave   bus,
    output state_t               dbg_state
);
    localparam int IDX_W = $clog2(NREQ);

    state_t            state, state_next;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win_idx;
    op_t               win_op;
    logic [NFLAGS-1:0] win_mask, win_data;
    logic [NFLAGS-1:0] flags_q, flags_next, op_val;
    logic [NREQ-1:0]   ack_q;

    logic              arb_valid;
    logic [IDX_W-1:0]  arb_winner;
    logic [1:0]        sel_op;
    logic [NFLAGS-1:0] sel_mask, sel_data;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req    (bus.req),
        .ptr    (ptr),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        sel_op   = '0;
        sel_mask = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_winner == IDX_W'(i)) begin
                sel_op   = bus.op[2*i +: 2];
                sel_mask = bus.mask[NFLAGS*i +: NFLAGS];
                sel_data = bus.data[NFLAGS*i +: NFLAGS];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (|bus.req) state_next = ST_ARB;
            ST_ARB:   state_next = arb_valid ? ST_APPLY : ST_IDLE;
            ST_APPLY: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Per-bit merge: masked bits take the op result, the rest keep their value.
    always_comb begin
        op_val = '0;
        case (win_op)
            OP_WRITE:  op_val = win_data;
            OP_SET:    op_val = '1;
            OP_CLEAR:  op_val = '0;
            OP_TOGGLE: op_val = ~flags_q;
            default:   op_val = '0;
        endcase
        flags_next = (flags_q & ~win_mask) | (op_val & win_mask);
    end

    always_ff @(posedge s_clock or posedge preset) begin
        if (preset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            win_idx  <= '0;
            win_op   <= OP_WRITE;
            win_mask <= '0;
            win_data <= '0;
            flags_q  <= RESET_FLAGS;
            ack_q    <= '0;
        end else begin
            state <= state_next;
            ack_q <= '0;
            if (state == ST_ARB && arb_valid) begin
                win_idx  <= arb_winner;
                win_op   <= op_t'(sel_op);
                win_mask <= sel_mask;
                win_data <= sel_data;
            end
            // Flags and ack land on the same edge, so they are visible together.
            if (state == ST_APPLY) begin
                flags_q <= flags_next;
                ack_q   <= NREQ'(1) << win_idx;
                if (win_idx == IDX_W'(NREQ - 1)) ptr <= '0;
                else                             ptr <= win_idx + 1'b1;
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.flags = flags_q;
    assign bus.busy  = (state != ST_IDLE);
    assign dbg_state = state;
endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Self-checking bench for flag_bank_arbiter with a round-robin / flag-merge reference model.
module tb_flag_bank_arbiter;
  import flag_bank_pkg::*;

  localparam int NREQ = 4;
  localparam int NFLAGS = 8;
  localparam logic [NFLAGS-1:0] RST_F = 8'hA5;

  logic s_clock = 1'b0;
  logic preset = 1'b1;
  state_t dbg_state;

  flag_bank_arbiter_if #(.NREQ(NREQ), .NFLAGS(NFLAGS)) bus ();

  flag_bank_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .RESET_FLAGS(RST_F)) dut (
    .s_clock   (s_clock),
    .preset    (preset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 s_clock = ~s_clock;

  int n_tests = 0;
  int n_fail = 0;

  logic [NREQ-1:0]   req_v;
  logic [1:0]        t_op[NREQ];
  logic [NFLAGS-1:0] t_mask[NREQ];
  logic [NFLAGS-1:0] t_data[NREQ];
  logic [NFLAGS-1:0] m_flags;
  int                m_ptr;

  // Reference model: spec-level rules, computed per bit and by linear search.
  function automatic logic [NFLAGS-1:0] model_apply(logic [NFLAGS-1:0] f, logic [1:0] op,
                                                    logic [NFLAGS-1:0] m, logic [NFLAGS-1:0] d);
    logic [NFLAGS-1:0] r;
    r = f;
    for (int b = 0; b < NFLAGS; b++) begin
      if (m[b]) begin
        case (op)
          2'b00: r[b] = d[b];
          2'b01: r[b] = 1'b1;
          2'b10: r[b] = 1'b0;
          default: r[b] = ~f[b];
        endcase
      end
    end
    return r;
  endfunction

  function automatic int model_winner(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Drivers
  task automatic drive_bus();
    bus.req = req_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.op[2*i +: 2] = t_op[i];
      bus.mask[NFLAGS*i +: NFLAGS] = t_mask[i];
      bus.data[NFLAGS*i +: NFLAGS] = t_data[i];
    end
  endtask

  task automatic load_txn(int i, logic [1:0] op, logic [NFLAGS-1:0] m, logic [NFLAGS-1:0] d);
    t_op[i] = op;
    t_mask[i] = m;
    t_data[i] = d;
  endtask

  task automatic load_random(int i);
    t_op[i] = 2'($urandom_range(0, 3));
    t_mask[i] = ($urandom_range(0, 3) == 0) ? '0 : NFLAGS'($urandom);
    t_data[i] = NFLAGS'($urandom);
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a, output int cyc, output bit ok);
    a = '0;
    cyc = 0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge s_clock);
      cyc++;
      if (bus.ack !== '0) begin
        a = bus.ack;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge s_clock);
    preset = 1'b1;
    req_v = '0;
    drive_bus();
    @(negedge s_clock);
    n_tests++;
    if (bus.flags !== RST_F) begin n_fail++; $display("FAIL reset_flags: got %h expected %h", bus.flags, RST_F); end
    n_tests++;
    if (bus.ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    preset = 1'b0;
    @(negedge s_clock);
    n_tests++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_release_state: got %0d expected IDLE", dbg_state); end
    m_flags = RST_F;
    m_ptr = 0;
  endtask

  task automatic test_single_write();
    logic [NREQ-1:0] a;
    int cyc;
    bit ok;
    load_txn(0, 2'b00, 8'h0F, 8'h03);
    req_v = 4'b0001;
    drive_bus();
    wait_ack(a, cyc, ok);
    req_v = '0;
    drive_bus();
    m_flags = model_apply(m_flags, 2'b00, 8'h0F, 8'h03);
    m_ptr = 1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_ack_timeout: got no ack expected 0001"); end
    n_tests++;
    if (cyc != 3) begin n_fail++; $display("FAIL write_latency: got %0d edges expected 3", cyc); end
    n_tests++;
    if (a !== 4'b0001) begin n_fail++; $display("FAIL write_ack: got %b expected 0001", a); end
    n_tests++;
    if (bus.flags !== 8'hA3 || bus.flags !== m_flags) begin
      n_fail++; $display("FAIL write_flags: got %h expected %h", bus.flags, 8'hA3);
    end
    @(negedge s_clock);
    n_tests++;
    if (bus.ack !== '0) begin n_fail++; $display("FAIL write_ack_single_cycle: got %b expected 0", bus.ack); end
  endtask

  task automatic test_set_clear_toggle();
    logic [1:0] ops[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [NFLAGS-1:0] msk[4] = '{8'hFF, 8'h80, 8'h01, 8'hFF};
    logic [NFLAGS-1:0] exp_f[4] = '{8'h00, 8'h80, 8'h80, 8'h7F};
    logic [NREQ-1:0] a;
    int cyc;
    bit ok;
    for (int j = 0; j < 4; j++) begin
      load_txn(2, ops[j], msk[j], 8'h00);
      req_v = 4'b0100;
      drive_bus();
      wait_ack(a, cyc, ok);
      req_v = '0;
      drive_bus();
      m_flags = model_apply(m_flags, ops[j], msk[j], 8'h00);
      n_tests++;
      if (a !== 4'b0100) begin n_fail++; $display("FAIL sct_ack[%0d]: got %b expected 0100", j, a); end
      n_tests++;
      if (bus.flags !== exp_f[j] || bus.flags !== m_flags) begin
        n_fail++; $display("FAIL sct_flags[%0d]: got %h expected %h", j, bus.flags, exp_f[j]);
      end
    end
    m_ptr = 3;
  endtask

  task automatic test_withdraw();
    logic [NFLAGS-1:0] saved;
    saved = m_flags;
    load_txn(3, 2'b01, 8'hFF, 8'h00);
    req_v = 4'b1000;
    drive_bus();
    @(negedge s_clock);
    n_tests++;
    if (dbg_state !== ST_ARB || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL withdraw_arb: got state %0d busy %b expected ARB busy 1", dbg_state, bus.busy);
    end
    req_v = '0;
    drive_bus();
    @(negedge s_clock);
    n_tests++;
    if (dbg_state !== ST_IDLE || bus.ack !== '0) begin
      n_fail++; $display("FAIL withdraw_idle: got state %0d ack %b expected IDLE ack 0", dbg_state, bus.ack);
    end
    @(negedge s_clock);
    n_tests++;
    if (bus.ack !== '0 || bus.flags !== saved) begin
      n_fail++; $display("FAIL withdraw_flags: got ack %b flags %h expected ack 0 flags %h", bus.ack, bus.flags, saved);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] a;
    int cyc;
    int exp;
    bit ok;
    @(negedge s_clock);
    preset = 1'b1;
    for (int i = 0; i < NREQ; i++) load_random(i);
    req_v = '1;
    drive_bus();
    @(negedge s_clock);
    preset = 1'b0;
    m_flags = RST_F;
    m_ptr = 0;
    for (int g = 0; g < 8; g++) begin
      wait_ack(a, cyc, ok);
      exp = model_winner(req_v, m_ptr);
      m_flags = model_apply(m_flags, t_op[exp], t_mask[exp], t_data[exp]);
      m_ptr = (exp + 1) % NREQ;
      n_tests++;
      if (!ok || a !== (NREQ'(1) << exp) || a !== (NREQ'(1) << (g % NREQ))) begin
        n_fail++; $display("FAIL fair_ack[%0d]: got %b expected %b", g, a, NREQ'(1) << exp);
      end
      n_tests++;
      if (cyc != 3) begin n_fail++; $display("FAIL fair_period[%0d]: got %0d expected 3", g, cyc); end
      n_tests++;
      if (bus.flags !== m_flags) begin n_fail++; $display("FAIL fair_flags[%0d]: got %h expected %h", g, bus.flags, m_flags); end
    end
    req_v = '0;
    drive_bus();
  endtask

  task automatic test_abort();
    logic [NREQ-1:0] a;
    int cyc;
    bit ok;
    @(negedge s_clock);
    preset = 1'b1;
    @(negedge s_clock);
    preset = 1'b0;
    m_flags = RST_F;
    // Grant requester 1 once so the pointer moves to 2 before the abort.
    load_txn(1, 2'b01, 8'hFF, 8'h00);
    req_v = 4'b0010;
    drive_bus();
    wait_ack(a, cyc, ok);
    n_tests++;
    if (!ok || a !== 4'b0010) begin n_fail++; $display("FAIL abort_pre_ack: got %b expected 0010", a); end
    load_txn(1, 2'b10, 8'hFF, 8'h00);
    load_txn(3, 2'b11, 8'h0F, 8'h00);
    drive_bus();
    @(negedge s_clock);
    @(negedge s_clock);
    n_tests++;
    if (dbg_state !== ST_APPLY) begin n_fail++; $display("FAIL abort_in_apply: got state %0d expected APPLY", dbg_state); end
    preset = 1'b1;
    @(negedge s_clock);
    n_tests++;
    if (bus.ack !== '0 || bus.flags !== RST_F) begin
      n_fail++; $display("FAIL abort_reset: got ack %b flags %h expected ack 0 flags %h", bus.ack, bus.flags, RST_F);
    end
    req_v = 4'b1010;
    drive_bus();
    preset = 1'b0;
    m_flags = RST_F;
    m_ptr = 0;
    wait_ack(a, cyc, ok);
    m_flags = model_apply(m_flags, t_op[1], t_mask[1], t_data[1]);
    m_ptr = 2;
    req_v = '0;
    drive_bus();
    n_tests++;
    if (!ok || a !== 4'b0010) begin n_fail++; $display("FAIL abort_next_grant: got %b expected 0010", a); end
    n_tests++;
    if (bus.flags !== m_flags) begin n_fail++; $display("FAIL abort_next_flags: got %h expected %h", bus.flags, m_flags); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] a;
    int cyc;
    int exp;
    int grants;
    int budget;
    int j;
    bit ok;
    grants = 0;
    budget = 16;
    for (int i = 0; i < NREQ; i++) load_random(i);
    req_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    drive_bus();
    while (req_v != '0 && grants < 60) begin
      wait_ack(a, cyc, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rand_timeout[%0d]: got no ack expected one", grants); break; end
      exp = model_winner(req_v, m_ptr);
      m_flags = model_apply(m_flags, t_op[exp], t_mask[exp], t_data[exp]);
      m_ptr = (exp + 1) % NREQ;
      n_tests++;
      if (a !== (NREQ'(1) << exp)) begin n_fail++; $display("FAIL rand_ack[%0d]: got %b expected %b", grants, a, NREQ'(1) << exp); end
      n_tests++;
      if (cyc != 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 3", grants, cyc); end
      n_tests++;
      if (bus.flags !== m_flags) begin n_fail++; $display("FAIL rand_flags[%0d]: got %h expected %h", grants, bus.flags, m_flags); end
      grants++;
      if (budget > 0 && $urandom_range(0, 1) == 1) begin
        load_random(exp);
        budget--;
      end else begin
        req_v[exp] = 1'b0;
      end
      if (budget > 0 && $urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, NREQ - 1);
        if (!req_v[j]) begin
          load_random(j);
          req_v[j] = 1'b1;
          budget--;
        end
      end
      drive_bus();
    end
    req_v = '0;
    drive_bus();
  endtask

  initial begin
    req_v = '0;
    for (int i = 0; i < NREQ; i++) load_txn(i, 2'b00, '0, '0);
    drive_bus();
    repeat (2) @(negedge s_clock);
    test_reset();
    test_single_write();
    test_set_clear_toggle();
    test_withdraw();
    test_fairness();
    test_abort();
    test_random();
    repeat (2) @(negedge s_clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
